// File: rtl/l2c_xin_pkg.sv
// rtl/l2c_xin_pkg.sv - XU command codes, field widths and packet type for the inbound receiver
package l2c_xin_pkg;

    localparam int XU_L2C_CMD_W   = 2;
    localparam int CORE_ADDR_W    = 32;
    localparam int CORE_UID_W     = 8;
    localparam int CPU_TILE_ID_W  = 4;
    localparam int CORE_DATA_W    = 32;
    localparam int CORE_DATA_BE_W = CORE_DATA_W / 8;

    localparam logic [XU_L2C_CMD_W-1:0] XU_L2C_CMD_NO  = 2'd0;
    localparam logic [XU_L2C_CMD_W-1:0] XU_L2C_CMD_RD  = 2'd1;
    localparam logic [XU_L2C_CMD_W-1:0] XU_L2C_CMD_WR  = 2'd2;
    localparam logic [XU_L2C_CMD_W-1:0] XU_L2C_CMD_FWD = 2'd3;

    typedef struct packed {
        logic [XU_L2C_CMD_W-1:0]   cmd;
        logic [CORE_ADDR_W-1:0]    addr;
        logic [CORE_UID_W-1:0]     uid;
        logic [CPU_TILE_ID_W-1:0]  src;
        logic [CORE_DATA_BE_W-1:0] data_be;
        logic [CORE_DATA_W-1:0]    data;
    } xin_pkt_t;

    function automatic logic cmd_legal(input logic [XU_L2C_CMD_W-1:0] cmd);
        return (cmd == XU_L2C_CMD_RD) || (cmd == XU_L2C_CMD_WR) || (cmd == XU_L2C_CMD_FWD);
    endfunction

endpackage

// File: rtl/l2c_xin_if.sv
// rtl/l2c_xin_if.sv - req/ack packet port shared by the XU input and the L2C/cbus outputs
interface l2c_xin_if;
    import l2c_xin_pkg::*;

    logic                      req;
    logic                      ack;
    logic [XU_L2C_CMD_W-1:0]   cmd;
    logic [CORE_ADDR_W-1:0]    addr;
    logic [CORE_UID_W-1:0]     uid;
    logic [CPU_TILE_ID_W-1:0]  src;
    logic [CORE_DATA_BE_W-1:0] data_be;
    logic [CORE_DATA_W-1:0]    data;

    modport master (output req, cmd, addr, uid, src, data_be, data, input ack);
    modport slave  (input req, cmd, addr, uid, src, data_be, data, output ack);

endinterface

// File: rtl/l2c_xin_fifo.sv
// rtl/l2c_xin_fifo.sv - generic power-of-two FIFO with occupancy count and full/empty flags
module l2c_xin_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = 1;
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW:0]   CNT_FULL = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    assign full  = (count == CNT_FULL);
    assign empty = (count == '0);
    assign rdata = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/l2c_xin.sv
// rtl/l2c_xin.sv - XU inbound receiver: buffers packets and steers the head to L2C or cbus
// Optional illegal-command discard enabled by defining L2C_XIN_CMD_CHECK_EN.
module l2c_xin
    import l2c_xin_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    l2c_xin_if.slave               xu,
    l2c_xin_if.master              l2c,
    l2c_xin_if.master              cbus,
    output logic                   cmd_err,
    output logic [$clog2(DEPTH):0] count
);
    localparam xin_pkt_t IDLE_PKT = '{cmd: XU_L2C_CMD_NO, default: '0};

    xin_pkt_t wr_pkt;
    xin_pkt_t head;
    xin_pkt_t l2c_pkt;
    xin_pkt_t cbus_pkt;
    logic     full;
    logic     empty;
    logic     accept;
    logic     pop;
    logic     to_l2c;
    logic     to_cbus;
    logic     discard;

    assign wr_pkt = '{cmd: xu.cmd, addr: xu.addr, uid: xu.uid, src: xu.src,
                      data_be: xu.data_be, data: xu.data};

    // full is taken before any same-cycle pop, so a full FIFO never passes through.
    assign accept = xu.req & ~full;
    assign xu.ack = accept;

`ifdef L2C_XIN_CMD_CHECK_EN
    assign to_cbus = ~empty & (head.cmd == XU_L2C_CMD_FWD);
    assign to_l2c  = ~empty & ((head.cmd == XU_L2C_CMD_RD) | (head.cmd == XU_L2C_CMD_WR));
    assign discard = ~empty & ~cmd_legal(head.cmd);
    assign cmd_err = discard;
`else
    assign to_cbus = ~empty & (head.cmd == XU_L2C_CMD_FWD);
    assign to_l2c  = ~empty & (head.cmd != XU_L2C_CMD_FWD);
    assign discard = 1'b0;
    assign cmd_err = 1'b0;
`endif

    assign pop = (to_l2c & l2c.ack) | (to_cbus & cbus.ack) | discard;

    l2c_xin_fifo #(
        .WIDTH ($bits(xin_pkt_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .wdata (wr_pkt),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign l2c_pkt  = to_l2c  ? head : IDLE_PKT;
    assign cbus_pkt = to_cbus ? head : IDLE_PKT;

    assign l2c.req     = to_l2c;
    assign l2c.cmd     = l2c_pkt.cmd;
    assign l2c.addr    = l2c_pkt.addr;
    assign l2c.uid     = l2c_pkt.uid;
    assign l2c.src     = l2c_pkt.src;
    assign l2c.data_be = l2c_pkt.data_be;
    assign l2c.data    = l2c_pkt.data;

    assign cbus.req     = to_cbus;
    assign cbus.cmd     = cbus_pkt.cmd;
    assign cbus.addr    = cbus_pkt.addr;
    assign cbus.uid     = cbus_pkt.uid;
    assign cbus.src     = cbus_pkt.src;
    assign cbus.data_be = cbus_pkt.data_be;
    assign cbus.data    = cbus_pkt.data;

endmodule

// File: tb/tb_l2c_xin.sv
// tb/tb_l2c_xin.sv - scoreboard bench for l2c_xin (directed vectors, monitor-side checking)
module tb_l2c_xin;
    import l2c_xin_pkg::*;

    localparam xin_pkt_t IDLE = '{cmd: XU_L2C_CMD_NO, default: '0};

    logic       clk;
    logic       rst;
    logic       cmd_err;
    logic [2:0] count;
    int         total = 0;
    int         bad   = 0;
    xin_pkt_t   exp_l2c[$];
    xin_pkt_t   exp_cbus[$];

    l2c_xin_if xu_if();
    l2c_xin_if l2c_if();
    l2c_xin_if cbus_if();

    l2c_xin #(.DEPTH(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .xu      (xu_if.slave),
        .l2c     (l2c_if.master),
        .cbus    (cbus_if.master),
        .cmd_err (cmd_err),
        .count   (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    function automatic xin_pkt_t port_pkt(input int which);
        xin_pkt_t p;
        if (which == 0)
            p = '{cmd: l2c_if.cmd, addr: l2c_if.addr, uid: l2c_if.uid, src: l2c_if.src,
                  data_be: l2c_if.data_be, data: l2c_if.data};
        else
            p = '{cmd: cbus_if.cmd, addr: cbus_if.addr, uid: cbus_if.uid, src: cbus_if.src,
                  data_be: cbus_if.data_be, data: cbus_if.data};
        return p;
    endfunction

    // Monitor: compare every downstream handshake against the scoreboard queues.
    always @(negedge clk) begin
        if (!rst && l2c_if.req && l2c_if.ack) begin
            if (exp_l2c.size() == 0) chk("l2c_unexpected", 128'(port_pkt(0)), 128'(IDLE));
            else chk("l2c_pkt", 128'(port_pkt(0)), 128'(exp_l2c.pop_front()));
            chk("l2c_cbus_idle", 128'({cbus_if.req, port_pkt(1)}), 128'({1'b0, IDLE}));
        end
        if (!rst && cbus_if.req && cbus_if.ack) begin
            if (exp_cbus.size() == 0) chk("cbus_unexpected", 128'(port_pkt(1)), 128'(IDLE));
            else chk("cbus_pkt", 128'(port_pkt(1)), 128'(exp_cbus.pop_front()));
            chk("cbus_l2c_idle", 128'({l2c_if.req, port_pkt(0)}), 128'({1'b0, IDLE}));
        end
    end

    // dest: 0 = L2C port, 1 = cbus port, 2 = no output expected
    task automatic send(input logic [1:0] c, input logic [31:0] a, input logic [7:0] u,
                        input logic [31:0] d, input int dest);
        xin_pkt_t p;
        bit got;
        p = '{cmd: c, addr: a, uid: u, src: 4'h5, data_be: 4'hF, data: d};
        xu_if.cmd = c; xu_if.addr = a; xu_if.uid = u; xu_if.src = 4'h5;
        xu_if.data_be = 4'hF; xu_if.data = d; xu_if.req = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            #1;
            if (xu_if.ack) got = 1'b1;
            else @(posedge clk);
        end
        if (!got) chk("send_timeout", 128'(0), 128'(1));
        else if (dest == 0) exp_l2c.push_back(p);
        else if (dest == 1) exp_cbus.push_back(p);
        @(posedge clk); #1;
        xu_if.req = 1'b0;
    endtask

    task automatic wait_empty(input string name);
        for (int i = 0; i < 50 && count != 0; i++) begin
            @(posedge clk); #1;
        end
        chk(name, 128'(count), 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        xu_if.req = 1'b0; xu_if.cmd = XU_L2C_CMD_NO; xu_if.addr = '0; xu_if.uid = '0;
        xu_if.src = '0; xu_if.data_be = '0; xu_if.data = '0;
        l2c_if.ack = 1'b0;
        cbus_if.ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ack", 128'(xu_if.ack), 128'(0));
        chk("rst_reqs", 128'({l2c_if.req, cbus_if.req}), 128'(0));
        chk("rst_cmd_err", 128'(cmd_err), 128'(0));
        chk("rst_count", 128'(count), 128'(0));
        chk("rst_l2c_idle", 128'(port_pkt(0)), 128'(IDLE));
        rst = 1'b0;
        @(posedge clk); #1;

        // Single RD: combinational ack, one-cycle latency to the L2C port.
        xu_if.cmd = XU_L2C_CMD_RD; xu_if.addr = 32'h100; xu_if.uid = 8'h1; xu_if.src = 4'h5;
        xu_if.data_be = 4'hF; xu_if.data = 32'h0; xu_if.req = 1'b1;
        #1;
        chk("rd_ack_same_cycle", 128'(xu_if.ack), 128'(1));
        exp_l2c.push_back('{cmd: XU_L2C_CMD_RD, addr: 32'h100, uid: 8'h1, src: 4'h5,
                            data_be: 4'hF, data: 32'h0});
        @(posedge clk); #1;
        xu_if.req = 1'b0;
        chk("rd_l2c_req", 128'({l2c_if.req, cbus_if.req}), 128'(2'b10));
        chk("rd_l2c_addr", 128'(l2c_if.addr), 128'(32'h100));
        chk("rd_count1", 128'(count), 128'(1));
        l2c_if.ack = 1'b1;
        @(posedge clk); #1;
        l2c_if.ack = 1'b0;
        chk("rd_count0", 128'(count), 128'(0));

        // FWD goes to cbus only.
        send(XU_L2C_CMD_FWD, 32'h80, 8'h3, 32'h1234, 1);
        chk("fwd_reqs", 128'({l2c_if.req, cbus_if.req}), 128'(2'b01));
        chk("fwd_l2c_cmd", 128'(l2c_if.cmd), 128'(XU_L2C_CMD_NO));
        chk("fwd_cbus_uid", 128'(cbus_if.uid), 128'(3));
        cbus_if.ack = 1'b1;
        @(posedge clk); #1;
        cbus_if.ack = 1'b0;
        chk("fwd_count0", 128'(count), 128'(0));

        // Fill to DEPTH, then full back-pressure and simultaneous push/pop.
        for (int i = 0; i < 4; i++) send(XU_L2C_CMD_RD, 32'h200 + i, 8'(i), 32'hA0 + i, 0);
        chk("full_count4", 128'(count), 128'(4));
        xu_if.cmd = XU_L2C_CMD_RD; xu_if.addr = 32'h204; xu_if.uid = 8'h4; xu_if.src = 4'h5;
        xu_if.data_be = 4'hF; xu_if.data = 32'hA4; xu_if.req = 1'b1;
        l2c_if.ack = 1'b1;
        #1;
        chk("full_ack0", 128'(xu_if.ack), 128'(0));
        @(posedge clk); #1;
        chk("after_pop_count3", 128'(count), 128'(3));
        chk("after_pop_ack1", 128'(xu_if.ack), 128'(1));
        exp_l2c.push_back('{cmd: XU_L2C_CMD_RD, addr: 32'h204, uid: 8'h4, src: 4'h5,
                            data_be: 4'hF, data: 32'hA4});
        @(posedge clk); #1;
        xu_if.req = 1'b0;
        chk("push_pop_count3", 128'(count), 128'(3));
        wait_empty("full_drain");
        l2c_if.ack = 1'b0;

        // Head-of-line blocking: stalled RD holds back FWD.
        send(XU_L2C_CMD_RD, 32'h300, 8'h7, 32'h0, 0);
        send(XU_L2C_CMD_FWD, 32'h400, 8'h8, 32'h0, 1);
        cbus_if.ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("hol_cbus_blocked", 128'(cbus_if.req), 128'(0));
            @(posedge clk); #1;
        end
        l2c_if.ack = 1'b1;
        @(posedge clk); #1;
        l2c_if.ack = 1'b0;
        chk("hol_cbus_released", 128'(cbus_if.req), 128'(1));
        @(posedge clk); #1;
        cbus_if.ack = 1'b0;
        chk("hol_count0", 128'(count), 128'(0));

        // Illegal command handling.
`ifdef L2C_XIN_CMD_CHECK_EN
        send(XU_L2C_CMD_NO, 32'h500, 8'h9, 32'h0, 2);
        chk("bad_reqs", 128'({l2c_if.req, cbus_if.req}), 128'(0));
        chk("bad_cmd_err1", 128'(cmd_err), 128'(1));
        @(posedge clk); #1;
        chk("bad_cmd_err0", 128'(cmd_err), 128'(0));
        chk("bad_count0", 128'(count), 128'(0));
`else
        send(XU_L2C_CMD_NO, 32'h500, 8'h9, 32'h0, 0);
        chk("no_to_l2c", 128'({l2c_if.req, cbus_if.req}), 128'(2'b10));
        chk("no_cmd_err0", 128'(cmd_err), 128'(0));
        l2c_if.ack = 1'b1;
        @(posedge clk); #1;
        l2c_if.ack = 1'b0;
        chk("no_count0", 128'(count), 128'(0));
`endif

        // Reset mid-operation discards everything immediately.
        for (int i = 0; i < 3; i++) send(XU_L2C_CMD_RD, 32'h600 + i, 8'h10, 32'h0, 2);
        chk("pre_rst_count3", 128'(count), 128'(3));
        rst = 1'b1;
        #1;
        chk("mid_rst_count0", 128'(count), 128'(0));
        chk("mid_rst_reqs", 128'({l2c_if.req, cbus_if.req}), 128'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        send(XU_L2C_CMD_WR, 32'h700, 8'h11, 32'hDEADBEEF, 0);
        chk("post_rst_data", 128'(l2c_if.data), 128'(32'hDEADBEEF));
        l2c_if.ack = 1'b1;
        @(posedge clk); #1;
        l2c_if.ack = 1'b0;
        chk("post_rst_count0", 128'(count), 128'(0));

        @(posedge clk); #1;
        chk("l2c_queue_drained", 128'(exp_l2c.size()), 128'(0));
        chk("cbus_queue_drained", 128'(exp_cbus.size()), 128'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
